// File: rtl/bnn_pkg.sv
// Shared constants and types for the binary-neural-network datapath blocks.
package bnn_pkg;
  localparam int WORD_W  = 16;
  localparam int ACC_W   = 11;
  localparam int BATCH_W = 6;
  localparam int ADDR_W  = 11;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } neuron_state_t;
endpackage

// File: rtl/popcount16.sv
// Combinational population count of a 16-bit word (0..16 in a 5-bit result).
module popcount16 (
  input  logic [15:0] word,
  output logic [4:0]  count
);
  always_comb begin
    count = '0;
    for (int i = 0; i < 16; i++) count = count + 5'(word[i]);
  end
endmodule

// File: rtl/xnor_neuron_acc.sv
// XNOR-popcount neuron accumulator with threshold and 16-bit output packer.
// Define XNOR_POPCOUNT_PIPE_EN to register the popcount before the accumulator.
module xnor_neuron_acc #(
  parameter int WORD_W = bnn_pkg::WORD_W,
  parameter int ACC_W  = bnn_pkg::ACC_W
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        start,
  input  logic [bnn_pkg::BATCH_W-1:0] batch,
  input  logic [WORD_W-1:0]           activation_in,
  input  logic                        activation_in_valid,
  input  logic [WORD_W-1:0]           weight_in,
  input  logic [ACC_W-1:0]            threshold,
  input  logic                        layer_start,
  input  logic [bnn_pkg::ADDR_W-1:0]  out_addr_base,
  input  logic                        flush,
  output logic                        result_bit,
  output logic                        result_valid,
  output logic [WORD_W-1:0]           out_word,
  output logic [bnn_pkg::ADDR_W-1:0]  out_addr,
  output logic                        out_we,
  output logic                        overflow_err
);
  import bnn_pkg::*;

  localparam int IDX_W = $clog2(WORD_W);

  neuron_state_t      state, state_nx;
  logic [BATCH_W-1:0] beats, batch_q, pend_batch;
  logic [ACC_W-1:0]   acc, thr_q, pend_thr, acc_sum;
  logic               pend;
  logic [4:0]         pc_p0, beat_pc;
  logic               beat_vld;
  logic               in_accum, beat_ok, last;
  logic               load_new, load_pend, capture, drop;

  logic [IDX_W-1:0]   idx;
  logic [WORD_W-1:0]  word, res_word;
  logic [ADDR_W-1:0]  word_count, addr_off;
  logic               emit;

  // Stage p0: XNOR and popcount of the incoming beat
  popcount16 u_popcount (
    .word  (~(activation_in ^ weight_in)),
    .count (pc_p0)
  );

`ifdef XNOR_POPCOUNT_PIPE_EN
  logic [4:0] pc_p1;
  logic       vld_p1;

  // Stage p1: registered popcount; beats only enter while a neuron is open
  always_ff @(posedge clk) begin
    pc_p1 <= pc_p0;
    if (!resetn) vld_p1 <= 1'b0;
    else         vld_p1 <= activation_in_valid && (state == ACCUM);
  end

  assign beat_pc  = pc_p1;
  assign beat_vld = vld_p1;
`else
  assign beat_pc  = pc_p0;
  assign beat_vld = activation_in_valid;
`endif

  assign in_accum = (state == ACCUM);
  assign beat_ok  = in_accum && beat_vld;
  assign last     = beat_ok && (beats == batch_q);
  assign acc_sum  = acc + ACC_W'(beat_pc);

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = ACCUM;
      ACCUM:   if (last && !pend && !start) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // A start coinciding with the last beat either chains directly or refills the slot
  always_comb begin
    load_new  = start && (!in_accum || (last && !pend));
    load_pend = last && pend;
    capture   = start && in_accum && (pend ? last : !last);
    drop      = start && in_accum && pend && !last;
  end

  // Stage p0/p1 -> accumulator and result register
  always_ff @(posedge clk) begin
    if (load_new) begin
      batch_q <= batch;
      thr_q   <= threshold;
      acc     <= '0;
      beats   <= '0;
    end else if (load_pend) begin
      batch_q <= pend_batch;
      thr_q   <= pend_thr;
      acc     <= '0;
      beats   <= '0;
    end else if (beat_ok) begin
      acc     <= acc_sum;
      beats   <= beats + 1'b1;
    end
    if (capture) begin
      pend_batch <= batch;
      pend_thr   <= threshold;
    end
    if (!resetn) begin
      pend         <= 1'b0;
      overflow_err <= 1'b0;
      result_valid <= 1'b0;
      result_bit   <= 1'b0;
    end else begin
      if (load_pend)    pend <= capture;
      else if (capture) pend <= 1'b1;
      if (drop) overflow_err <= 1'b1;
      result_valid <= last;
      if (last) result_bit <= (acc_sum >= thr_q);
    end
  end

  always_comb begin
    res_word = word;
    if (result_valid) res_word[idx] = result_bit;
    if (result_valid) emit = (idx == IDX_W'(WORD_W - 1)) || flush;
    else              emit = flush && (idx != '0);
  end

  // Result register -> packed write request
  always_ff @(posedge clk) begin
    if (!resetn) begin
      idx        <= '0;
      word       <= '0;
      word_count <= '0;
      addr_off   <= '0;
      out_word   <= '0;
      out_we     <= 1'b0;
    end else begin
      out_we <= emit;
      if (emit) begin
        out_word <= res_word;
        addr_off <= word_count;
      end
      if (layer_start) begin
        idx        <= '0;
        word       <= '0;
        word_count <= '0;
      end else if (emit) begin
        idx        <= '0;
        word       <= '0;
        word_count <= word_count + 1'b1;
      end else if (result_valid) begin
        idx  <= idx + 1'b1;
        word <= res_word;
      end
    end
  end

  assign out_addr = out_addr_base + addr_off;
endmodule
